// File: rtl/sensor_alarm_ctrl_pkg.sv
// Shared types and constants for the sensor alarm controller.
// Sensor bit positions match the upstream error detector.
package sensor_pkg;

    localparam int SENSOR_W = 4;

    localparam int SENS_A = 0;
    localparam int SENS_B = 1;
    localparam int SENS_C = 2;
    localparam int SENS_D = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        ALARM   = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    function automatic logic local_error(logic [SENSOR_W-1:0] s);
        return s[SENS_A]
             | (s[SENS_D] & s[SENS_B])
             | (s[SENS_C] & s[SENS_B]);
    endfunction

endpackage

// File: rtl/sensor_alarm_ctrl_if.sv
// Sensor/host bundle for the alarm controller.
// master = sensor/host side, slave = controller side.
interface sensor_alarm_ctrl_if #(
    parameter int CNT_WIDTH = 8
);
    import sensor_pkg::*;

    logic [SENSOR_W-1:0]  sensors;
    logic                 error;
    logic                 alarm_ack;
    logic                 alarm;
    logic [SENSOR_W-1:0]  fault_code;
    logic [CNT_WIDTH-1:0] event_count;
    logic [1:0]           state_o;

    modport master (
        output sensors,
        output error,
        output alarm_ack,
        input  alarm,
        input  fault_code,
        input  event_count,
        input  state_o
    );

    modport slave (
        input  sensors,
        input  error,
        input  alarm_ack,
        output alarm,
        output fault_code,
        output event_count,
        output state_o
    );

endinterface

// File: rtl/sensor_alarm_ctrl_qual_cnt.sv
// Debounce counter: counts consecutive qualifying samples and
// flags the terminal count at DEBOUNCE_CYCLES-1.
module sensor_qual_cnt #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [W-1:0] TC_VAL = W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/sensor_alarm_ctrl.sv
// Debounced, latched sensor alarm with fault capture and event count.
// SENSOR_ALARM_LOCAL_DETECT_EN: derive error from sensors, ignore port.
module sensor_alarm_ctrl
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                clk,
    input  logic                rst,
    sensor_alarm_ctrl_if.slave  bus
);

    state_t               state;
    state_t               state_nx;
    logic                 err;
    logic                 qual_en;
    logic                 qual_clr;
    logic                 qual_tc;
    logic                 enter_alarm;
    logic [SENSOR_W-1:0]  fault_q;
    logic [CNT_WIDTH-1:0] evt_q;

`ifdef SENSOR_ALARM_LOCAL_DETECT_EN
    logic unused_error;
    assign unused_error = bus.error;
    assign err = local_error(bus.sensors);
`else
    assign err = bus.error;
`endif

    sensor_qual_cnt #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_qual (
        .clk (clk),
        .rst (rst),
        .clr (qual_clr),
        .en  (qual_en),
        .tc  (qual_tc)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (err) begin
                    state_nx = (DEBOUNCE_CYCLES == 1) ? ALARM : QUALIFY;
                end
            end
            QUALIFY: begin
                if (!err) begin
                    state_nx = IDLE;
                end else if (qual_tc) begin
                    state_nx = ALARM;
                end
            end
            ALARM: begin
                if (bus.alarm_ack) begin
                    state_nx = err ? CLEAR : IDLE;
                end
            end
            CLEAR: begin
                // Must see error low once before re-arming
                if (!err) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign qual_en     = (state_nx == QUALIFY);
    assign qual_clr    = !qual_en;
    assign enter_alarm = (state_nx == ALARM) && (state != ALARM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fault_q <= '0;
            evt_q   <= '0;
        end else begin
            state <= state_nx;
            if (enter_alarm) begin
                fault_q <= bus.sensors;
                if (evt_q != '1) begin
                    evt_q <= evt_q + 1'b1;
                end
            end
        end
    end

    assign bus.alarm       = (state == ALARM);
    assign bus.state_o     = state;
    assign bus.fault_code  = fault_q;
    assign bus.event_count = evt_q;

endmodule
